risc_run_ctrl: RTL and testbench

Parametrised run controller for the risc_kgp core. Owns the core's reset sequencing and multi-phase timing from a single clock. Generates NUM_PHASES one-cycle phase enables (generalising the fixed clk/clka/clkb skew) and counts instruction frames. Stops the core on a halt request or on a programmable cycle budget, and reports the outcome. It sits between the top-level clock/reset and the core plus its memory ports.

---
 rtl/risc_kgp_pkg.sv | 25 ++
 rtl/risc_frame_counter.sv | 41 ++++
 rtl/risc_run_ctrl.sv | 126 ++++++++++++
 tb/tb_risc_run_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_kgp_pkg.sv
// Shared types and configuration checks for the risc_kgp run controller.
// The state enum encoding is visible on the controller's debug state output.
package risc_kgp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

    // Every phase offset must fall inside one frame and the core needs at least one reset cycle.
    function automatic bit phase_cfg_ok(
        input int num_phases,
        input int period,
        input int phase_step,
        input int reset_hold
    );
        return (num_phases >= 1) &&
               (period >= num_phases) &&
               ((num_phases - 1) * phase_step < period) &&
               (reset_hold >= 1);
    endfunction

endpackage

// File: rtl/risc_frame_counter.sv
// Instruction-frame counter with per-phase one-cycle enables.
// The counter sits at zero whenever it is not enabled, so a new run always starts at frame 0.
module risc_frame_counter #(
    parameter int NUM_PHASES = 2,
    parameter int PERIOD     = 4,
    parameter int PHASE_STEP = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  frame_last,
    output logic [NUM_PHASES-1:0] phase_en
);

    localparam int FRAME_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PERIOD - 1);

    logic [FRAME_W-1:0] r_frame;

    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            r_frame <= '0;
        end else if (r_frame == FRAME_LAST) begin
            r_frame <= '0;
        end else begin
            r_frame <= r_frame + 1'b1;
        end
    end

    assign frame_last = enable && (r_frame == FRAME_LAST);

    always_comb begin
        phase_en = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (enable && (r_frame == FRAME_W'(k * PHASE_STEP))) begin
                phase_en[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller for the risc_kgp core: reset sequencing, phase enables,
// frame counting and halt/budget termination, all from one clock.
module risc_run_ctrl
    import risc_kgp_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int PERIOD     = 4,
    parameter int PHASE_STEP = 2,
    parameter int RESET_HOLD = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic [CNT_W-1:0]      budget,
    output logic                  core_rst,
    output logic                  run,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic                  done,
    output logic                  timeout,
    output logic [1:0]            dbg_state
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    if (!phase_cfg_ok(NUM_PHASES, PERIOD, PHASE_STEP, RESET_HOLD)) begin : g_cfg_error
        $error("risc_run_ctrl: illegal NUM_PHASES/PERIOD/PHASE_STEP/RESET_HOLD combination");
    end

    run_state_t         r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]   r_budget;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic               r_core_rst;
    logic               r_run;
    logic               r_done;
    logic               r_timeout;

    logic               w_frame_last;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_budget_hit;

    risc_frame_counter #(
        .NUM_PHASES (NUM_PHASES),
        .PERIOD     (PERIOD),
        .PHASE_STEP (PHASE_STEP)
    ) u_frame (
        .clk        (clk),
        .reset      (reset),
        .enable     (r_run),
        .frame_last (w_frame_last),
        .phase_en   (phase_en)
    );

    // Unlimited runs (budget 0) saturate instead of wrapping the frame count.
    assign w_cnt_next   = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + 1'b1;
    assign w_budget_hit = (r_budget != '0) && (w_cnt_next == r_budget);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_budget    <= '0;
            r_cycle_cnt <= '0;
            r_core_rst  <= 1'b1;
            r_run       <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_HOLD;
                        r_hold_cnt  <= '0;
                        r_budget    <= budget;
                        r_cycle_cnt <= '0;
                        r_core_rst  <= 1'b1;
                        r_run       <= 1'b0;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b0;
                        r_run      <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A frame finishing on the halt edge still counts; halt wins over budget.
                    if (w_frame_last) begin
                        r_cycle_cnt <= w_cnt_next;
                    end
                    if (halt_req) begin
                        r_state   <= ST_DONE;
                        r_run     <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b0;
                    end else if (w_frame_last && w_budget_hit) begin
                        r_state   <= ST_DONE;
                        r_run     <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_rst  = r_core_rst;
    assign run       = r_run;
    assign cycle_cnt = r_cycle_cnt;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Bench for risc_run_ctrl: directed timing scenarios plus random traffic,
// scored cycle-by-cycle against a frame/phase reference model.
module tb_risc_run_ctrl;
    import risc_kgp_pkg::*;

    localparam int NUM_PHASES = 2;
    localparam int PERIOD     = 4;
    localparam int PHASE_STEP = 2;
    localparam int RESET_HOLD = 3;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0]            st;
        logic                  core_rst;
        logic                  run;
        logic [NUM_PHASES-1:0] ph;
        logic [CNT_W-1:0]      cnt;
        logic                  done;
        logic                  to;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    logic                  start;
    logic                  halt_req;
    logic [CNT_W-1:0]      budget;
    logic                  core_rst;
    logic                  run;
    logic [NUM_PHASES-1:0] phase_en;
    logic [CNT_W-1:0]      cycle_cnt;
    logic                  done;
    logic                  timeout;
    logic [1:0]            dbg_state;

    risc_run_ctrl #(
        .NUM_PHASES (NUM_PHASES),
        .PERIOD     (PERIOD),
        .PHASE_STEP (PHASE_STEP),
        .RESET_HOLD (RESET_HOLD),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .halt_req  (halt_req),
        .budget    (budget),
        .core_rst  (core_rst),
        .run       (run),
        .phase_en  (phase_en),
        .cycle_cnt (cycle_cnt),
        .done      (done),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Narrow-counter instance for the saturation case.
    logic                  s_start;
    logic [3:0]            s_budget;
    logic                  s_core_rst;
    logic                  s_run;
    logic [NUM_PHASES-1:0] s_phase_en;
    logic [3:0]            s_cycle_cnt;
    logic                  s_done;
    logic                  s_timeout;
    logic [1:0]            s_dbg_state;

    risc_run_ctrl #(
        .NUM_PHASES (NUM_PHASES),
        .PERIOD     (PERIOD),
        .PHASE_STEP (PHASE_STEP),
        .RESET_HOLD (RESET_HOLD),
        .CNT_W      (4)
    ) u_sat (
        .clk       (clk),
        .reset     (rst_n),
        .start     (s_start),
        .halt_req  (1'b0),
        .budget    (s_budget),
        .core_rst  (s_core_rst),
        .run       (s_run),
        .phase_en  (s_phase_en),
        .cycle_cnt (s_cycle_cnt),
        .done      (s_done),
        .timeout   (s_timeout),
        .dbg_state (s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int base     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    int m_mode      = M_IDLE;
    int m_hold_left = 0;
    int m_run_cyc   = 0;
    int m_cnt       = 0;
    int m_bud       = 0;
    bit m_to        = 1'b0;

    function automatic logic [1:0] mode_state(input int mode);
        case (mode)
            M_HOLD:  return ST_HOLD;
            M_RUN:   return ST_RUN;
            M_DONE:  return ST_DONE;
            default: return ST_IDLE;
        endcase
    endfunction

    // Applies one clock edge with the current inputs, then queues the outputs of the new cycle.
    task automatic model_edge();
        bit   fin;
        exp_t e;
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_to   = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        m_mode      = M_HOLD;
                        m_hold_left = RESET_HOLD;
                        m_bud       = int'(budget);
                        m_cnt       = 0;
                        m_to        = 1'b0;
                    end
                end
                M_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_mode    = M_RUN;
                        m_run_cyc = 0;
                    end
                end
                M_RUN: begin
                    m_run_cyc++;
                    fin = ((m_run_cyc % PERIOD) == 0);
                    if (fin && m_cnt < CNT_MAX) m_cnt++;
                    if (halt_req) begin
                        m_mode = M_DONE;
                        m_to   = 1'b0;
                    end else if (fin && m_bud != 0 && m_cnt == m_bud) begin
                        m_mode = M_DONE;
                        m_to   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        e.st       = mode_state(m_mode);
        e.core_rst = (m_mode == M_IDLE) || (m_mode == M_HOLD);
        e.run      = (m_mode == M_RUN);
        for (int k = 0; k < NUM_PHASES; k++) begin
            e.ph[k] = (m_mode == M_RUN) && ((m_run_cyc % PERIOD) == k * PHASE_STEP);
        end
        e.cnt  = CNT_W'(m_cnt);
        e.done = (m_mode == M_DONE);
        e.to   = m_to;
        exp_q.push_back(EXP_W'(e));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            chk("state",     32'(dbg_state), 32'(e.st));
            chk("core_rst",  32'(core_rst),  32'(e.core_rst));
            chk("run",       32'(run),       32'(e.run));
            chk("phase_en",  32'(phase_en),  32'(e.ph));
            chk("cycle_cnt", 32'(cycle_cnt), 32'(e.cnt));
            chk("done",      32'(done),      32'(e.done));
            chk("timeout",   32'(timeout),   32'(e.to));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit rn, input bit st, input bit hr, input logic [CNT_W-1:0] bu);
        rst_n    = rn;
        start    = st;
        halt_req = hr;
        budget   = bu;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    // Issues start during the current cycle; that cycle becomes cycle 0 of the scenario.
    task automatic start_run(input logic [CNT_W-1:0] bu);
        base = cyc;
        step(1'b1, 1'b1, 1'b0, bu);
    endtask

    task automatic idle_until(input int c);
        while (cyc - base < c) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        budget   = '0;
        s_start  = 1'b0;
        s_budget = '0;

        // Reset state
        do_reset();
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_outputs",  {26'd0, run, phase_en, done, timeout}, 32'd0);
        chk("rst_cnt",      32'(cycle_cnt), 32'd0);
        chk("rst_state",    32'(dbg_state), 32'(ST_IDLE));

        // Phase pattern, unlimited budget
        step(1'b1, 1'b0, 1'b0, '0);
        start_run('0);
        idle_until(3);  chk("hold_core_rst", 32'(core_rst), 32'd1);
                        chk("hold_run", 32'(run), 32'd0);
        idle_until(4);  chk("run_start", 32'(run), 32'd1);
                        chk("ph_c4", 32'(phase_en), 32'b01);
        idle_until(6);  chk("ph_c6", 32'(phase_en), 32'b10);
        idle_until(7);  chk("cnt_c7", 32'(cycle_cnt), 32'd0);
        idle_until(8);  chk("cnt_c8", 32'(cycle_cnt), 32'd1);
                        chk("ph_c8", 32'(phase_en), 32'b01);
        idle_until(14); chk("ph_c14", 32'(phase_en), 32'b10);

        // Budget exit
        do_reset();
        start_run(16'd5);
        idle_until(23); chk("bud_c23_done", 32'(done), 32'd0);
                        chk("bud_c23_cnt", 32'(cycle_cnt), 32'd4);
        idle_until(24); chk("bud_done", 32'(done), 32'd1);
                        chk("bud_timeout", 32'(timeout), 32'd1);
                        chk("bud_cnt", 32'(cycle_cnt), 32'd5);
                        chk("bud_ph", 32'(phase_en), 32'd0);
        idle_until(30); chk("bud_frozen", 32'(cycle_cnt), 32'd5);

        // Halt mid-frame
        do_reset();
        start_run('0);
        idle_until(9);
        step(1'b1, 1'b0, 1'b1, '0);
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_timeout", 32'(timeout), 32'd0);
        chk("halt_cnt", 32'(cycle_cnt), 32'd1);
        chk("halt_ph", 32'(phase_en), 32'd0);

        // Halt on the budget edge
        do_reset();
        start_run(16'd2);
        idle_until(11);
        step(1'b1, 1'b0, 1'b1, '0);
        chk("hb_done", 32'(done), 32'd1);
        chk("hb_timeout", 32'(timeout), 32'd0);
        chk("hb_cnt", 32'(cycle_cnt), 32'd2);

        // Restart from DONE
        start_run('0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_core_rst", 32'(core_rst), 32'd1);
        chk("rs_cnt", 32'(cycle_cnt), 32'd0);
        idle_until(4);  chk("rs_run", 32'(run), 32'd1);
                        chk("rs_ph", 32'(phase_en), 32'b01);

        // Mid-run reset, then a fresh start
        do_reset();
        start_run('0);
        idle_until(10);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("mr_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("mr_core_rst", 32'(core_rst), 32'd1);
        chk("mr_cnt", 32'(cycle_cnt), 32'd0);
        start_run('0);
        idle_until(3);  chk("mr_c3_run", 32'(run), 32'd0);
        idle_until(4);  chk("mr_c4_run", 32'(run), 32'd1);
                        chk("mr_c4_ph", 32'(phase_en), 32'b01);

        // start during RUN is ignored, including its budget
        do_reset();
        start_run(16'd3);
        idle_until(6);
        step(1'b1, 1'b1, 1'b0, 16'd7);
        idle_until(15); chk("ign_c15_done", 32'(done), 32'd0);
        idle_until(16); chk("ign_done", 32'(done), 32'd1);
                        chk("ign_cnt", 32'(cycle_cnt), 32'd3);
                        chk("ign_timeout", 32'(timeout), 32'd1);

        // Saturation with a 4-bit counter
        do_reset();
        base    = cyc;
        s_start = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);
        s_start = 1'b0;
        idle_until(63); chk("sat_c63", 32'(s_cycle_cnt), 32'd14);
        idle_until(64); chk("sat_c64", 32'(s_cycle_cnt), 32'd15);
                        chk("sat_ph", 32'(s_phase_en), 32'b01);
                        chk("sat_core_rst", 32'(s_core_rst), 32'd0);
        idle_until(120); chk("sat_hold", 32'(s_cycle_cnt), 32'd15);
                         chk("sat_run", 32'(s_run), 32'd1);
                         chk("sat_state", 32'(s_dbg_state), 32'(ST_RUN));
                         chk("sat_flags", {30'd0, s_done, s_timeout}, 32'd0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 29) == 0),
                 CNT_W'($urandom_range(0, 6)));
        end
        step(1'b1, 1'b0, 1'b0, '0);

        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
